keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans the calculator's 4x5 matrix keypad and drives the key-event inputs of the calculator control FSM.
- Debounces each press and emits one single-cycle strobe per press, plus digit value or operator code held alongside.
- Sits between the board keypad pins and the control FSM's dig/op/sub/ex/bksp/MS/MR/MC/reset inputs.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before advancing; must be >= 4.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a press, and again to accept a release.
- REPEAT_PERIOD, 5000000: cycles between repeated backspace strobes (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- col_n  out  5  column drive, active-low, one-hot-low while scanning
- row_n  in  4  row sense, active-low (external pull-ups), asynchronous to clock
- dig_out  out  1  one-cycle strobe, digit key
- digit  out  4  digit value 0-9; valid with dig_out, held until the next digit press
- op_out  out  1  one-cycle strobe, operator key (+ - * /)
- op_code  out  2  00 add, 01 sub, 10 mul, 11 div; held until the next operator press
- sub_out  out  1  one-cycle strobe, minus key
- ex_out  out  1  one-cycle strobe, '=' key
- bksp_out  out  1  one-cycle strobe, backspace key
- reset_key_out  out  1  one-cycle strobe, 'C' key
- MS_out, MR_out, MC_out  out  1 each  one-cycle memory-key strobes

Behaviour:
- Key map, row r / col c:
  - r0: 1 2 3 + MS
  - r1: 4 5 6 - MR
  - r2: 7 8 9 * MC
  - r3: C 0 BKSP / =
- Minus key asserts sub_out and op_out in the same cycle, with op_code=01, so the control FSM treats it as a sign in start/oprnd and as an operator in op_A.
- All other keys assert exactly one strobe.
- row_n passes through a 2-flop synchronizer before any use.
- Reset values:
  - state SCAN, col_n=5'b11110, all strobes 0, digit=0, op_code=00, all counters 0.
- State SCAN:
  - Drive the current column low for SCAN_DIV cycles.
  - On the last dwell cycle, sample the synchronized rows.
  - If any row is low, latch (row, col) and go to DEBOUNCE; the column stays driven.
  - Otherwise advance the column, 4 wraps to 0.
  - If several rows are low, the lowest row index wins.
- State DEBOUNCE:
  - Count cycles while the latched row stays low.
  - If it goes high, return to SCAN and resume at the next column.
  - When the count reaches DEBOUNCE_CYCLES, go to EMIT.
- State EMIT (exactly 1 cycle):
  - Assert the decoded strobe(s).
  - Update digit/op_code in the same cycle.
  - Go to HELD.
- State HELD:
  - No strobes.
  - Wait until the latched row has read high for DEBOUNCE_CYCLES consecutive cycles; any low reading restarts the count.
  - Then return to SCAN at the next column.
- Keys pressed while another key is HELD are ignored; no rollover.
- Strobes are mutually exclusive except the minus pair; never two strobes in consecutive cycles from one press.
- Latency from the first synchronized low sample to the strobe is DEBOUNCE_CYCLES+1 cycles.
- Reset asserted mid-debounce or mid-hold: return to reset values immediately; a still-held key is re-detected and emitted once after reset.
- Counters are wide enough for max(SCAN_DIV, DEBOUNCE_CYCLES, REPEAT_PERIOD) and saturate, never wrap.

Optional Feature:
- Macro: KEYPAD_BKSP_REPEAT_EN.
- Defined: while BKSP is in HELD and still pressed, a further bksp_out strobe fires every REPEAT_PERIOD cycles, the first one REPEAT_PERIOD cycles after EMIT; release handling is unchanged.
- Undefined: backspace behaves like every other key, one strobe per press, and the REPEAT_PERIOD logic is absent.

Test Plan:
- SCAN_DIV=4, DEBOUNCE_CYCLES=8, hold key '7' (r2,c0) stable for 40 cycles -> exactly one dig_out pulse with digit=7, col_n frozen at 11110 while held; scanning resumes at col 1 after release plus 8 stable-high cycles.
- Press minus (r1,c3) -> one cycle with sub_out=1, op_out=1, op_code=01; all other strobes 0.
- Key '5' bounces low/high every 3 cycles for 30 cycles, then stays low -> no strobe during bouncing; one dig_out with digit=5 exactly 9 cycles after stable low begins.
- Hold '1' and '4' together in col 0 -> only digit=1 emitted; pressing '=' while '1' is held -> no ex_out.
- Assert reset during DEBOUNCE of 'C' -> all outputs at reset values; key still held -> single reset_key_out after re-detection.
- With KEYPAD_BKSP_REPEAT_EN, REPEAT_PERIOD=20, hold BKSP for 75 cycles after EMIT -> bksp_out pulses at EMIT, +20, +40, +60; without the macro, exactly one pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x5 active-low key matrix, debounces press/release, emits one-shot key strobes.
// Define KEYPAD_BKSP_REPEAT_EN to auto-repeat backspace every REPEAT_PERIOD cycles while it is held.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    output logic [4:0] col_n,
    input  logic [3:0] row_n,
    output logic       dig_out,
    output logic [3:0] digit,
    output logic       op_out,
    output logic [1:0] op_code,
    output logic       sub_out,
    output logic       ex_out,
    output logic       bksp_out,
    output logic       reset_key_out,
    output logic       MS_out,
    output logic       MR_out,
    output logic       MC_out
);
    localparam int MAX_SD = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int MAX_C  = (MAX_SD > REPEAT_PERIOD) ? MAX_SD : REPEAT_PERIOD;
    localparam int CW     = $clog2(MAX_C + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, HELD} state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_sync1, r_sync2, w_low, r_digit, w_dval;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [2:0]    r_col, w_col_nxt, w_col_adv;
    logic [1:0]    r_row, w_row_nxt, w_low_row, r_op;
    logic          w_row_low, w_emit, w_rep, w_r3, w_dig;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= row_n;
            r_sync2 <= r_sync1;
        end
    end

    // Lowest-numbered low row wins when several keys share the driven column.
    assign w_low     = ~r_sync2;
    assign w_low_row = w_low[0] ? 2'd0 : w_low[1] ? 2'd1 : w_low[2] ? 2'd2 : 2'd3;
    assign w_row_low = w_low[r_row];
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_col_adv = (r_col == 3'd4) ? 3'd0 : r_col + 3'd1;

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = w_cnt_inc;
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        case (r_state)
            SCAN: begin
                if (r_cnt == CW'(SCAN_DIV - 1)) begin
                    w_cnt_nxt = '0;
                    if (|w_low) begin
                        w_next    = DEBOUNCE;
                        w_row_nxt = w_low_row;
                    end else begin
                        w_col_nxt = w_col_adv;
                    end
                end
            end
            DEBOUNCE: begin
                if (!w_row_low) begin
                    w_next    = SCAN;
                    w_cnt_nxt = '0;
                    w_col_nxt = w_col_adv;
                end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    w_next    = EMIT;
                    w_cnt_nxt = '0;
                end
            end
            EMIT: begin
                w_next    = HELD;
                w_cnt_nxt = '0;
            end
            HELD: begin
                if (w_row_low) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    w_next    = SCAN;
                    w_cnt_nxt = '0;
                    w_col_nxt = w_col_adv;
                end
            end
        endcase
    end

    assign w_r3   = (r_row == 2'd3);
    assign w_dig  = (r_col < 3'd3 && !w_r3) || (w_r3 && r_col == 3'd1);
    assign w_dval = w_r3 ? 4'd0 : {2'b00, r_row} * 4'd3 + {1'b0, r_col} + 4'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= SCAN;
            r_cnt   <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_digit <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            if (w_next == EMIT && w_dig) r_digit <= w_dval;
            if (w_next == EMIT && r_col == 3'd3) r_op <= r_row;
        end
    end

`ifdef KEYPAD_BKSP_REPEAT_EN
    logic [CW-1:0] r_rep;
    // Period counter restarts on entering HELD and whenever the key reads released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_rep <= '0;
        else r_rep <= (r_state != HELD || !w_row_low || w_rep) ? '0 : r_rep + 1'b1;
    end
    assign w_rep = (r_state == HELD) && w_row_low && (r_rep == CW'(REPEAT_PERIOD - 1));
`else
    assign w_rep = 1'b0;
`endif

    assign w_emit        = (r_state == EMIT);
    assign col_n         = ~(5'd1 << r_col);
    assign digit         = r_digit;
    assign op_code       = r_op;
    assign dig_out       = w_emit & w_dig;
    assign op_out        = w_emit & (r_col == 3'd3);
    assign sub_out       = w_emit & (r_col == 3'd3) & (r_row == 2'd1);
    assign ex_out        = w_emit & w_r3 & (r_col == 3'd4);
    assign reset_key_out = w_emit & w_r3 & (r_col == 3'd0);
    assign bksp_out      = (w_emit | w_rep) & w_r3 & (r_col == 3'd2);
    assign MS_out        = w_emit & (r_row == 2'd0) & (r_col == 3'd4);
    assign MR_out        = w_emit & (r_row == 2'd1) & (r_col == 3'd4);
    assign MC_out        = w_emit & (r_row == 2'd2) & (r_col == 3'd4);
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and random key presses on a modelled switch matrix, checked against the key map.
module tb_keypad_scanner;
    localparam int SD = 4, DB = 8, RP = 20, LAT = SD + DB;
    localparam logic [8:0] DG = 9'h100, OP = 9'h080, SB = 9'h040, EX = 9'h020, BK = 9'h010;
    localparam logic [8:0] RK = 9'h008, MS = 9'h004, MR = 9'h002, MC = 9'h001;
    localparam logic [8:0] MASK [20] = '{DG, DG, DG, OP, MS, DG, DG, DG, OP | SB, MR,
                                         DG, DG, DG, OP, MC, RK, DG, BK, OP, EX};
    localparam int DIG [20] = '{1, 2, 3, -1, -1, 4, 5, 6, -1, -1, 7, 8, 9, -1, -1, -1, 0, -1, -1, -1};
    localparam int OPC [20] = '{-1, -1, -1, 0, -1, -1, -1, -1, 1, -1, -1, -1, -1, 2, -1, -1, -1, -1, 3, -1};

    typedef struct {int t; int lat; logic [8:0] s; logic [3:0] d; logic [1:0] o;} ev_t;

    logic       clock = 1'b0, reset = 1'b1;
    logic [4:0] col_n;
    logic [3:0] row_n, digit;
    logic [1:0] op_code;
    logic       dig_out, op_out, sub_out, ex_out, bksp_out, reset_key_out, MS_out, MR_out, MC_out;
    logic [8:0] stb;
    logic [4:0] pressed [4];
    int         cyc = 0, n_tests = 0, n_fail = 0, exp_d = 0, exp_o = 0;
    int         start [5];
    ev_t        evq [$];

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .REPEAT_PERIOD(RP)) dut (
        .clock(clock), .reset(reset), .col_n(col_n), .row_n(row_n),
        .dig_out(dig_out), .digit(digit), .op_out(op_out), .op_code(op_code),
        .sub_out(sub_out), .ex_out(ex_out), .bksp_out(bksp_out), .reset_key_out(reset_key_out),
        .MS_out(MS_out), .MR_out(MR_out), .MC_out(MC_out)
    );

    assign stb = {dig_out, op_out, sub_out, ex_out, bksp_out, reset_key_out, MS_out, MR_out, MC_out};

    always_comb for (int r = 0; r < 4; r++) row_n[r] = ~|(pressed[r] & ~col_n);

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Record when each column dwell begins, and every strobe with its latency from that dwell start.
    initial begin
        logic [4:0] prev;
        ev_t        e;
        int         ci;
        prev = '1;
        forever begin
            @(negedge clock);
            if (reset) start[0] = cyc;
            else if (col_n != prev) for (int i = 0; i < 5; i++) if (!col_n[i]) start[i] = cyc;
            prev = col_n;
            if (|stb) begin
                ci = 0;
                for (int i = 0; i < 5; i++) if (!col_n[i]) ci = i;
                e.t = cyc; e.lat = cyc - start[ci]; e.s = stb; e.d = digit; e.o = op_code;
                evq.push_back(e);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ev(input int idx, input string tag);
        int n = 0;
        while (evq.size() <= idx && n < 100) begin
            tick(1);
            n++;
        end
        chk({tag, "_seen"}, 32'(evq.size() > idx), 1);
    endtask

    task automatic settle(input int col, input string tag);
        int         t0 = cyc, n = 0;
        logic [4:0] c0 = col_n, ec;
        ec = ~(5'd1 << ((col + 1) % 5));
        while (col_n == c0 && n < 60) begin
            tick(1);
            n++;
        end
        chk({tag, "_resume_dt"}, cyc - t0, DB + 2);
        chk({tag, "_resume_col"}, col_n, ec);
    endtask

    task automatic check_ev(input int idx, input int k, input string tag);
        if (DIG[k] >= 0) exp_d = DIG[k];
        if (OPC[k] >= 0) exp_o = OPC[k];
        chk({tag, "_count"}, evq.size() - idx, 1);
        if (evq.size() > idx) begin
            chk({tag, "_mask"}, evq[idx].s, MASK[k]);
            chk({tag, "_digit"}, evq[idx].d, exp_d);
            chk({tag, "_opcode"}, evq[idx].o, exp_o);
            chk({tag, "_latency"}, evq[idx].lat, LAT);
        end
        chk({tag, "_digit_held"}, digit, exp_d);
        chk({tag, "_opcode_held"}, op_code, exp_o);
    endtask

    task automatic do_press(input int r, input int c, input int hold, input int bounce, input string tag);
        int         idx = evq.size(), bad = 0;
        logic [4:0] ec;
        ec = ~(5'd1 << c);
        for (int i = 0; i < bounce; i++) begin
            pressed[r][c] = ((i / 3) % 2 == 0);
            tick(1);
        end
        if (bounce > 0) chk({tag, "_bounce_quiet"}, evq.size() - idx, 0);
        pressed[r][c] = 1'b1;
        wait_ev(idx, tag);
        for (int i = 0; i < hold; i++) begin
            if (col_n !== ec) bad++;
            tick(1);
        end
        chk({tag, "_col_frozen_bad"}, bad, 0);
        pressed[r][c] = 1'b0;
        settle(c, tag);
        check_ev(idx, r * 5 + c, tag);
    endtask

    initial begin
        int idx, t0, k, nexp;
        for (int r = 0; r < 4; r++) pressed[r] = '0;
        tick(3);
        chk("rst_col", col_n, 5'b11110);
        chk("rst_strobes", stb, 0);
        chk("rst_digit", digit, 0);
        chk("rst_opcode", op_code, 0);
        reset = 1'b0;

        do_press(2, 0, 28, 0, "key7");
        do_press(1, 3, 10, 0, "minus");
        do_press(1, 1, 10, 30, "bounce5");

        idx = evq.size();
        pressed[0][0] = 1'b1;
        pressed[1][0] = 1'b1;
        wait_ev(idx, "multi");
        tick(3);
        pressed[3][4] = 1'b1;
        tick(30);
        pressed[3][4] = 1'b0;
        tick(2);
        pressed[0][0] = 1'b0;
        pressed[1][0] = 1'b0;
        settle(0, "multi");
        check_ev(idx, 0, "multi");

        do_press(3, 3, 5, 0, "div");

        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        pressed[3][0] = 1'b1;
        idx = evq.size();
        tick(8);
        chk("rstC_quiet", evq.size() - idx, 0);
        reset = 1'b1;
        tick(1);
        chk("rstC_col", col_n, 5'b11110);
        chk("rstC_strobes", stb, 0);
        chk("rstC_digit", digit, 0);
        chk("rstC_opcode", op_code, 0);
        exp_d = 0;
        exp_o = 0;
        tick(1);
        reset = 1'b0;
        wait_ev(idx, "rstC");
        tick(10);
        pressed[3][0] = 1'b0;
        settle(0, "rstC");
        check_ev(idx, 15, "rstC");

        idx = evq.size();
        pressed[3][2] = 1'b1;
        wait_ev(idx, "bksp");
        t0 = cyc;
        tick(75);
        pressed[3][2] = 1'b0;
        settle(2, "bksp");
`ifdef KEYPAD_BKSP_REPEAT_EN
        nexp = 4;
`else
        nexp = 1;
`endif
        chk("bksp_count", evq.size() - idx, nexp);
        for (int i = 0; i < nexp && idx + i < evq.size(); i++) begin
            chk("bksp_mask", evq[idx + i].s, BK);
            if (i > 0) chk("bksp_period", evq[idx + i].t - t0, RP * i);
        end
        if (evq.size() > idx) chk("bksp_latency", evq[idx].lat, LAT);

        for (int n = 0; n < 24; n++) begin
            k = $urandom_range(19, 0);
`ifdef KEYPAD_BKSP_REPEAT_EN
            if (k == 17) k = 16;
`endif
            do_press(k / 5, k % 5, $urandom_range(30, 1), 0, "rnd");
            tick($urandom_range(8, 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
